// File: rtl/apu_playback_scheduler.sv
// Round-robin front end for a single apu: grants one of two playback requests,
// programs the apu window, fires it, services lookahead and tracks playback end.
module apu_playback_scheduler #(
    parameter int          ADDR_W  = 10,
    parameter int          TONE_W  = 4,
    parameter logic [31:0] TIMEOUT = 32'd4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [ADDR_W-1:0] req_start_a,
    input  logic [ADDR_W-1:0] req_end_a,
    input  logic [ADDR_W-1:0] req_start_b,
    input  logic [ADDR_W-1:0] req_end_b,
    output logic [1:0]        req_ready,
    input  logic              stop,
    output logic [ADDR_W-1:0] apu_start_addr,
    output logic [ADDR_W-1:0] apu_end_addr,
    output logic              apu_send_oneshot,
    input  logic              apu_note_clk,
    input  logic              apu_lookahead_ready,
    input  logic [TONE_W-1:0] apu_lookahead_tone,
    output logic              apu_acknowledge_lookahead,
    output logic [TONE_W-1:0] next_tone,
    output logic              next_tone_valid,
    output logic              busy,
    output logic              done,
    output logic              done_id,
    output logic              aborted,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, LOAD, FIRE, PLAY, DONE} state_t;

    state_t            state_q;
    logic              ptr_q;
    logic [ADDR_W-1:0] start_q, end_q, len_q, cnt_q;
    logic [31:0]       tmo_q;
    logic              note_q, armed_q;
    logic [1:0]        req_ready_q;
    logic [ADDR_W-1:0] apu_start_q, apu_end_q;
    logic              oneshot_q, ack_q, tone_vld_q;
    logic [TONE_W-1:0] tone_q;
    logic              busy_q, done_q, done_id_q, aborted_q, err_q;

    logic              gnt_d;
    logic [ADDR_W-1:0] sel_start_d, sel_end_d, cnt_d;
    logic              note_edge_d, last_note_d, tmo_hit_d;

    assign gnt_d       = req_valid[ptr_q] ? ptr_q : ~ptr_q;
    assign sel_start_d = gnt_d ? req_start_b : req_start_a;
    assign sel_end_d   = gnt_d ? req_end_b   : req_end_a;
    assign cnt_d       = cnt_q + ADDR_W'(1);
    assign note_edge_d = apu_note_clk & ~note_q;
    assign last_note_d = note_edge_d && (cnt_d == len_q);
    assign tmo_hit_d   = (tmo_q == TIMEOUT - 32'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            start_q     <= '0;
            end_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            note_q      <= 1'b0;
            armed_q     <= 1'b1;
            req_ready_q <= '0;
            apu_start_q <= '0;
            apu_end_q   <= '0;
            oneshot_q   <= 1'b0;
            ack_q       <= 1'b0;
            tone_q      <= '0;
            tone_vld_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= 1'b0;
            aborted_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            note_q      <= apu_note_clk;
            req_ready_q <= '0;
            oneshot_q   <= 1'b0;
            ack_q       <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            err_q       <= 1'b0;
            if (!apu_lookahead_ready)
                armed_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    // req_ready is registered, so the requester still shows valid in the
                    // cycle its ready is visible; skip that cycle to avoid a double grant.
                    if (req_valid != 2'b00 && req_ready_q == 2'b00) begin
                        req_ready_q <= gnt_d ? 2'b10 : 2'b01;
                        ptr_q       <= ~gnt_d;
                        if (sel_start_d >= sel_end_d) begin
                            err_q <= 1'b1;
                        end else begin
                            start_q   <= sel_start_d;
                            end_q     <= sel_end_d;
                            len_q     <= sel_end_d - sel_start_d;
                            done_id_q <= gnt_d;
                            busy_q    <= 1'b1;
                            state_q   <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    apu_start_q <= start_q;
                    apu_end_q   <= end_q;
                    state_q     <= FIRE;
                end
                FIRE: begin
                    oneshot_q  <= 1'b1;
                    cnt_q      <= '0;
                    tmo_q      <= '0;
                    tone_vld_q <= 1'b0;
                    state_q    <= PLAY;
                end
                PLAY: begin
                    if (apu_lookahead_ready && armed_q) begin
                        ack_q      <= 1'b1;
                        tone_q     <= apu_lookahead_tone;
                        tone_vld_q <= 1'b1;
                        armed_q    <= 1'b0;
                    end
                    // Final note beats a same-cycle stop or timeout.
                    if (last_note_d) begin
                        cnt_q   <= cnt_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (stop) begin
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                        state_q   <= DONE;
                    end else if (note_edge_d) begin
                        cnt_q <= cnt_d;
                        tmo_q <= '0;
                    end else if (tmo_hit_d) begin
                        err_q     <= 1'b1;
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready                 = req_ready_q;
    assign apu_start_addr            = apu_start_q;
    assign apu_end_addr              = apu_end_q;
    assign apu_send_oneshot          = oneshot_q;
    assign apu_acknowledge_lookahead = ack_q;
    assign next_tone                 = tone_q;
    assign next_tone_valid           = tone_vld_q;
    assign busy                      = busy_q;
    assign done                      = done_q;
    assign done_id                   = done_id_q;
    assign aborted                   = aborted_q;
    assign err                       = err_q;

endmodule

// File: tb/tb_apu_playback_scheduler.sv
// Self-checking bench for apu_playback_scheduler: directed scenarios plus a
// randomized request/playback run checked against a round-robin reference model.
module tb_apu_playback_scheduler;
    localparam int          ADDR_W = 10;
    localparam int          TONE_W = 4;
    localparam logic [31:0] TMO    = 32'd64;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [1:0]        req_valid = '0;
    logic [ADDR_W-1:0] req_start_a = '0, req_end_a = '0, req_start_b = '0, req_end_b = '0;
    logic [1:0]        req_ready;
    logic              stop = 1'b0;
    logic [ADDR_W-1:0] apu_start_addr, apu_end_addr;
    logic              apu_send_oneshot;
    logic              apu_note_clk = 1'b0;
    logic              apu_lookahead_ready = 1'b0;
    logic [TONE_W-1:0] apu_lookahead_tone = '0;
    logic              apu_acknowledge_lookahead;
    logic [TONE_W-1:0] next_tone;
    logic              next_tone_valid, busy, done, done_id, aborted, err;

    int   total = 0, bad = 0;
    int   n_oneshot = 0, n_ack = 0, n_err = 0, n_done = 0;
    logic last_id = 1'b0, last_ab = 1'b0;
    int   ptr_m = 0;

    apu_playback_scheduler #(.ADDR_W(ADDR_W), .TONE_W(TONE_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid),
        .req_start_a(req_start_a), .req_end_a(req_end_a),
        .req_start_b(req_start_b), .req_end_b(req_end_b),
        .req_ready(req_ready), .stop(stop),
        .apu_start_addr(apu_start_addr), .apu_end_addr(apu_end_addr),
        .apu_send_oneshot(apu_send_oneshot), .apu_note_clk(apu_note_clk),
        .apu_lookahead_ready(apu_lookahead_ready), .apu_lookahead_tone(apu_lookahead_tone),
        .apu_acknowledge_lookahead(apu_acknowledge_lookahead),
        .next_tone(next_tone), .next_tone_valid(next_tone_valid),
        .busy(busy), .done(done), .done_id(done_id), .aborted(aborted), .err(err)
    );

    always #5 clk = ~clk;

    // Event monitor: counts pulses and remembers the last completion.
    always @(negedge clk) begin
        if (apu_send_oneshot === 1'b1) n_oneshot++;
        if (apu_acknowledge_lookahead === 1'b1) n_ack++;
        if (err === 1'b1) n_err++;
        if (done === 1'b1) begin
            n_done++;
            last_id = done_id;
            last_ab = aborted;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [33:0] out_vec();
        return {req_ready, apu_start_addr, apu_end_addr, apu_send_oneshot,
                apu_acknowledge_lookahead, next_tone, next_tone_valid,
                busy, done, done_id, aborted, err};
    endfunction

    // Round-robin reference: pointed requester if valid, else the other one.
    function automatic int rr_pick(input logic [1:0] mask);
        return (mask[ptr_m] == 1'b1) ? ptr_m : 1 - ptr_m;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Raise the given valid bits, wait (bounded) for a ready pulse, then withdraw.
    task automatic request(input logic [1:0] mask, output logic [1:0] served);
        served = 2'b00;
        req_valid = mask;
        for (int i = 0; i < 20; i++) begin
            step();
            if (req_ready != 2'b00) begin
                served = req_ready;
                break;
            end
        end
        req_valid = 2'b00;
    endtask

    // Called right after the grant: wait for PLAY, send notes, optionally stop.
    task automatic run_play(input int notes, input int gap, input bit do_stop);
        step();
        step();
        for (int k = 0; k < notes; k++) begin
            apu_note_clk = 1'b1;
            step();
            apu_note_clk = 1'b0;
            repeat (1 + gap) step();
        end
        if (do_stop) begin
            stop = 1'b1;
            step();
            stop = 1'b0;
        end
        repeat (2) step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        total++;
        if (out_vec() !== 34'd0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", out_vec());
        end
        reset = 1'b1;
        ptr_m = 0;
        step();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        logic [1:0] srv;
        int d0;
        req_start_a = 10'd4;  req_end_a = 10'd6;
        req_start_b = 10'd10; req_end_b = 10'd13;
        d0 = n_done;
        request(2'b11, srv);
        total++;
        if (srv !== 2'b01) begin bad++; $display("FAIL rr_first: got %b want 01", srv); end
        ptr_m = 1;
        run_play(2, 0, 1'b0);
        total++;
        if (n_done !== d0 + 1 || last_id !== 1'b0 || last_ab !== 1'b0) begin
            bad++; $display("FAIL rr_first_done: got n=%0d id=%b ab=%b want n=%0d id=0 ab=0",
                            n_done - d0, last_id, last_ab, 1);
        end
        request(2'b11, srv);
        total++;
        if (srv !== 2'b10) begin bad++; $display("FAIL rr_second: got %b want 10", srv); end
        ptr_m = 0;
        run_play(3, 1, 1'b0);
        total++;
        if (n_done !== d0 + 2 || last_id !== 1'b1 || last_ab !== 1'b0) begin
            bad++; $display("FAIL rr_second_done: got n=%0d id=%b ab=%b want n=2 id=1 ab=0",
                            n_done - d0, last_id, last_ab);
        end
        request(2'b10, srv);
        total++;
        if (srv !== 2'b10) begin bad++; $display("FAIL rr_b_only: got %b want 10", srv); end
        ptr_m = 0;
        run_play(3, 0, 1'b0);
    endtask

    task automatic test_single_a();
        logic [1:0] srv;
        logic [2:0] fin;
        logic early;
        req_start_a = 10'd0; req_end_a = 10'd16;
        request(2'b01, srv);
        total++;
        if (srv !== 2'b01 || busy !== 1'b1) begin
            bad++; $display("FAIL single_grant: got ready=%b busy=%b want 01 1", srv, busy);
        end
        ptr_m = 1;
        step();
        total++;
        if (apu_start_addr !== 10'd0 || apu_end_addr !== 10'd16 || req_ready !== 2'b00 ||
            apu_send_oneshot !== 1'b0) begin
            bad++; $display("FAIL single_addr: got %0d..%0d ready=%b os=%b want 0..16 00 0",
                            apu_start_addr, apu_end_addr, req_ready, apu_send_oneshot);
        end
        step();
        total++;
        if (apu_send_oneshot !== 1'b1) begin
            bad++; $display("FAIL single_oneshot: got %b want 1", apu_send_oneshot);
        end
        early = 1'b0;
        fin = 3'b000;
        for (int k = 0; k < 16; k++) begin
            apu_note_clk = 1'b1;
            step();
            if (k < 15 && done === 1'b1) early = 1'b1;
            if (k == 15) fin = {done, done_id, aborted};
            apu_note_clk = 1'b0;
            step();
        end
        total++;
        if (early !== 1'b0) begin bad++; $display("FAIL single_early: got done before note 16 want none"); end
        total++;
        if (fin !== 3'b100) begin
            bad++; $display("FAIL single_done: got done/id/ab=%b want 100", fin);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL single_idle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_lookahead();
        logic [1:0] srv;
        int a0, d0;
        req_start_a = 10'd0; req_end_a = 10'd200;
        request(2'b01, srv);
        ptr_m = 1;
        a0 = n_ack;
        d0 = n_done;
        step();
        step();
        apu_lookahead_tone  = 4'hA;
        apu_lookahead_ready = 1'b1;
        repeat (20) step();
        total++;
        if (n_ack - a0 !== 1 || {next_tone_valid, next_tone} !== 5'h1A) begin
            bad++; $display("FAIL la_first: got acks=%0d tone=%b/%h want 1 1/a",
                            n_ack - a0, next_tone_valid, next_tone);
        end
        apu_lookahead_ready = 1'b0;
        apu_lookahead_tone  = 4'h0;
        repeat (3) step();
        apu_lookahead_tone  = 4'h3;
        apu_lookahead_ready = 1'b1;
        repeat (5) step();
        apu_lookahead_ready = 1'b0;
        step();
        total++;
        if (n_ack - a0 !== 2 || {next_tone_valid, next_tone} !== 5'h13) begin
            bad++; $display("FAIL la_second: got acks=%0d tone=%b/%h want 2 1/3",
                            n_ack - a0, next_tone_valid, next_tone);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        repeat (2) step();
        total++;
        if (n_done !== d0 + 1 || last_ab !== 1'b1 || {next_tone_valid, next_tone} !== 5'h13) begin
            bad++; $display("FAIL la_persist: got n=%0d ab=%b tone=%b/%h want 1 1 1/3",
                            n_done - d0, last_ab, next_tone_valid, next_tone);
        end
    endtask

    task automatic test_reject();
        logic [1:0] srv;
        int e0, o0;
        logic seen_err, seen_busy;
        req_start_b = 10'd8; req_end_b = 10'd8;
        e0 = n_err;
        o0 = n_oneshot;
        request(2'b10, srv);
        seen_err  = err;
        seen_busy = busy;
        ptr_m = 0;
        total++;
        if (srv !== 2'b10 || seen_err !== 1'b1 || seen_busy !== 1'b0) begin
            bad++; $display("FAIL reject_pulse: got ready=%b err=%b busy=%b want 10 1 0",
                            srv, seen_err, seen_busy);
        end
        repeat (4) step();
        total++;
        if (n_err - e0 !== 1 || n_oneshot !== o0 || busy !== 1'b0) begin
            bad++; $display("FAIL reject_after: got errs=%0d oneshots=%0d busy=%b want 1 0 0",
                            n_err - e0, n_oneshot - o0, busy);
        end
    endtask

    task automatic test_timeout();
        logic [1:0] srv;
        int cyc;
        logic [3:0] fin;
        req_start_b = 10'd0; req_end_b = 10'd50;
        request(2'b10, srv);
        ptr_m = 0;
        step();
        step();
        total++;
        if (apu_send_oneshot !== 1'b1 || next_tone_valid !== 1'b0) begin
            bad++; $display("FAIL tmo_fire: got os=%b ntv=%b want 1 0", apu_send_oneshot, next_tone_valid);
        end
        for (int k = 0; k < 2; k++) begin
            apu_note_clk = 1'b1;
            step();
            apu_note_clk = 1'b0;
            if (k == 0) step();
        end
        cyc = 0;
        fin = 4'b0000;
        for (int i = 0; i < 100; i++) begin
            step();
            cyc++;
            if (done === 1'b1) begin
                fin = {done, err, aborted, done_id};
                break;
            end
        end
        total++;
        if (cyc !== 64 || fin !== 4'b1111) begin
            bad++; $display("FAIL tmo_done: got cycles=%0d done/err/ab/id=%b want 64 1111", cyc, fin);
        end
        repeat (2) step();
    endtask

    task automatic test_stop();
        logic [1:0] srv;
        int d0, e0;
        logic [1:0] fin;
        req_start_a = 10'd0; req_end_a = 10'd30;
        d0 = n_done;
        e0 = n_err;
        request(2'b01, srv);
        ptr_m = 1;
        run_play(5, 0, 1'b1);
        total++;
        if (n_done !== d0 + 1 || last_id !== 1'b0 || last_ab !== 1'b1 || n_err !== e0) begin
            bad++; $display("FAIL stop_done: got n=%0d id=%b ab=%b errs=%0d want 1 0 1 0",
                            n_done - d0, last_id, last_ab, n_err - e0);
        end
        req_start_a = 10'd0; req_end_a = 10'd3;
        request(2'b01, srv);
        ptr_m = 1;
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            apu_note_clk = 1'b1; step(); apu_note_clk = 1'b0; step();
        end
        apu_note_clk = 1'b1;
        stop = 1'b1;
        step();
        fin = {done, aborted};
        apu_note_clk = 1'b0;
        stop = 1'b0;
        total++;
        if (fin !== 2'b10) begin
            bad++; $display("FAIL stop_vs_last_note: got done/ab=%b want 10", fin);
        end
        repeat (2) step();
    endtask

    task automatic test_reset_mid_play();
        logic [1:0] srv;
        req_start_a = 10'd0; req_end_a = 10'd20;
        req_start_b = 10'd0; req_end_b = 10'd20;
        request(2'b01, srv);
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            apu_note_clk = 1'b1; step(); apu_note_clk = 1'b0; step();
        end
        reset = 1'b0;
        #1;
        total++;
        if (out_vec() !== 34'd0) begin
            bad++; $display("FAIL midreset_outputs: got %h want 0", out_vec());
        end
        step();
        reset = 1'b1;
        ptr_m = 0;
        step();
        request(2'b11, srv);
        total++;
        if (srv !== 2'b01) begin bad++; $display("FAIL midreset_grant: got %b want 01", srv); end
        ptr_m = 1;
        run_play(0, 0, 1'b1);
    endtask

    task automatic test_random();
        logic [1:0] mask, srv;
        logic [ADDR_W-1:0] s[2], e[2];
        int g, len, notes, gap, d0, o0, e0;
        bit do_stop;
        for (int it = 0; it < 30; it++) begin
            mask = 2'($urandom_range(1, 3));
            for (int r = 0; r < 2; r++) begin
                s[r] = ADDR_W'($urandom_range(3, 40));
                if ($urandom_range(0, 4) == 0) e[r] = s[r] - ADDR_W'($urandom_range(0, 3));
                else                           e[r] = s[r] + ADDR_W'($urandom_range(1, 10));
            end
            req_start_a = s[0]; req_end_a = e[0];
            req_start_b = s[1]; req_end_b = e[1];
            g = rr_pick(mask);
            ptr_m = 1 - g;
            d0 = n_done; o0 = n_oneshot; e0 = n_err;
            request(mask, srv);
            total++;
            if (srv !== (2'b01 << g)) begin
                bad++; $display("FAIL rand_grant[%0d]: got %b want %b", it, srv, 2'b01 << g);
            end
            if (s[g] >= e[g]) begin
                repeat (2) step();
                total++;
                if (n_err - e0 !== 1 || n_oneshot !== o0 || n_done !== d0) begin
                    bad++; $display("FAIL rand_reject[%0d]: got errs=%0d os=%0d dones=%0d want 1 0 0",
                                    it, n_err - e0, n_oneshot - o0, n_done - d0);
                end
            end else begin
                len     = int'(e[g] - s[g]);
                do_stop = ($urandom_range(0, 3) == 0);
                notes   = do_stop ? $urandom_range(0, len - 1) : len;
                gap     = $urandom_range(0, 2);
                run_play(notes, gap, do_stop);
                total++;
                if (n_done !== d0 + 1 || n_oneshot !== o0 + 1 || last_id !== g[0] ||
                    last_ab !== do_stop || n_err !== e0) begin
                    bad++; $display("FAIL rand_play[%0d]: got n=%0d os=%0d id=%b ab=%b errs=%0d want 1 1 %0d %0d 0",
                                    it, n_done - d0, n_oneshot - o0, last_id, last_ab, n_err - e0, g, do_stop);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_a();
        test_lookahead();
        test_reject();
        test_timeout();
        test_stop();
        test_reset_mid_play();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
